// File: rtl/bounce_sprites_pkg.sv
// Shared types, screen geometry and helpers for the bouncing-sprite renderer.
package bounce_sprites_pkg;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned BOX_WIDTH     = 100;
  localparam int unsigned BOX_HEIGHT    = 100;
  localparam int unsigned VEL_BITS      = 4;
  localparam int unsigned CW            = 3;
  localparam int unsigned XW            = $clog2(SCREEN_WIDTH);
  localparam int unsigned YW            = $clog2(SCREEN_HEIGHT);
  localparam int unsigned PW            = XW + 2;

  typedef logic signed [PW-1:0]       pos_t;
  typedef logic signed [VEL_BITS-1:0] vel_t;
  typedef logic [CW-1:0]              colour_t;

  localparam pos_t MAX_X = pos_t'(SCREEN_WIDTH - BOX_WIDTH);
  localparam pos_t MAX_Y = pos_t'(SCREEN_HEIGHT - BOX_HEIGHT);

  typedef struct packed {
    pos_t    x;
    pos_t    y;
    vel_t    xv;
    vel_t    yv;
    colour_t colour;
  } box_t;

  // Colour cycles 1..7 and wraps back to 1, never producing black.
  function automatic colour_t next_colour(input colour_t c);
    return (c == colour_t'(7) || c == colour_t'(0)) ? colour_t'(1) : colour_t'(c + colour_t'(1));
  endfunction

  // Power-on placement of box i: staggered positions, alternating x direction.
  function automatic box_t reset_box(input int i);
    box_t b;
    b.x      = pos_t'(50 + 40 * i);
    b.y      = pos_t'(50 + 30 * i);
    b.xv     = ((i % 2) == 1) ? vel_t'(-2) : vel_t'(2);
    b.yv     = vel_t'(1 + (i % 2));
    b.colour = colour_t'((i % 7) + 1);
    return b;
  endfunction

endpackage

// File: rtl/bounce_sprites_if.sv
// Video-timer inputs and colour/status outputs of the sprite renderer.
interface bounce_sprites_if;
  import bounce_sprites_pkg::*;

  logic          frame_tick;
  logic          pause;
  logic          visible;
  logic [XW-1:0] position_x;
  logic [YW-1:0] position_y;
  logic [3:0]    r;
  logic [3:0]    g;
  logic [3:0]    b;
  logic          busy;
  logic          overrun;

  modport master (
    output frame_tick, pause, visible, position_x, position_y,
    input  r, g, b, busy, overrun
  );

  modport slave (
    input  frame_tick, pause, visible, position_x, position_y,
    output r, g, b, busy, overrun
  );

endinterface

// File: rtl/bounce_sprites_axis.sv
// One-axis bounce step: advance by velocity, clamp at 0 / max and reflect.
module bounce_axis
  import bounce_sprites_pkg::*;
(
  input  pos_t i_p,
  input  vel_t i_v,
  input  pos_t i_max,
  output pos_t o_p_next,
  output vel_t o_v_next,
  output logic o_hit
);

  pos_t w_v_ext;
  pos_t w_t;

  assign w_v_ext = {{(PW - VEL_BITS){i_v[VEL_BITS-1]}}, i_v};
  assign w_t     = i_p + w_v_ext;

  // Clamp to the wall and reverse direction when the step reaches either edge.
  always_comb begin
    o_p_next = w_t;
    o_v_next = i_v;
    o_hit    = 1'b0;
    if (w_t <= pos_t'(0)) begin
      o_p_next = pos_t'(0);
      o_v_next = -i_v;
      o_hit    = 1'b1;
    end else if (w_t >= i_max) begin
      o_p_next = i_max;
      o_v_next = -i_v;
      o_hit    = 1'b1;
    end
  end

endmodule

// File: rtl/bounce_sprites.sv
// Multi-box bouncing-sprite renderer: per-frame sequential update engine plus
// priority compositor working from shadow copies so the picture never tears.
module bounce_sprites #(
  parameter int unsigned NUM_BOXES = 4
) (
  input  logic       clk,
  input  logic       rst,
  bounce_sprites_if.slave bus
);
  import bounce_sprites_pkg::*;

  localparam int unsigned   IW       = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BOXES - 1);
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_UPDATE = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_next;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_next;
  logic          r_busy;
  logic          r_overrun;
  logic [3:0]    r_r;
  logic [3:0]    r_g;
  logic [3:0]    r_b;

  box_t          r_work   [NUM_BOXES];
  box_t          r_shadow [NUM_BOXES];

  box_t          w_cur;
  box_t          w_upd;
  pos_t          w_x_next;
  pos_t          w_y_next;
  vel_t          w_xv_next;
  vel_t          w_yv_next;
  logic          w_hit_x;
  logic          w_hit_y;
  logic          w_last;
  pos_t          w_px;
  pos_t          w_py;
  logic          w_any;
  colour_t       w_col;

  assign w_cur  = r_work[r_idx];
  assign w_last = (r_idx == LAST_IDX);

  bounce_axis u_axis_x (
    .i_p      (w_cur.x),
    .i_v      (w_cur.xv),
    .i_max    (MAX_X),
    .o_p_next (w_x_next),
    .o_v_next (w_xv_next),
    .o_hit    (w_hit_x)
  );

  bounce_axis u_axis_y (
    .i_p      (w_cur.y),
    .i_v      (w_cur.yv),
    .i_max    (MAX_Y),
    .o_p_next (w_y_next),
    .o_v_next (w_yv_next),
    .o_hit    (w_hit_y)
  );

  // Assemble the stepped box; colour advances on a hit on either axis.
  always_comb begin
    w_upd        = w_cur;
    w_upd.x      = w_x_next;
    w_upd.y      = w_y_next;
    w_upd.xv     = w_xv_next;
    w_upd.yv     = w_yv_next;
    w_upd.colour = (w_hit_x || w_hit_y) ? next_colour(w_cur.colour) : w_cur.colour;
  end

  // Next-state logic: a tick starts a sweep over all boxes, one per cycle.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_tick && !bus.pause) begin
          w_state_next = S_UPDATE;
          w_idx_next   = '0;
        end
      end
      S_UPDATE: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_idx_next = r_idx + IW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, index and busy flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_busy  <= (w_state_next == S_UPDATE);
    end
  end

  // Sticky flag for a tick that lands while a sweep is still running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (bus.frame_tick && (r_state == S_UPDATE)) begin
      r_overrun <= 1'b1;
    end
  end

  // Working boxes step during the sweep; shadows take the whole set at its end.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_BOXES); i++) begin
        r_work[i]   <= reset_box(i);
        r_shadow[i] <= reset_box(i);
      end
    end else if (r_state == S_UPDATE) begin
      r_work[r_idx] <= w_upd;
      if (w_last) begin
        for (int i = 0; i < int'(NUM_BOXES); i++) begin
          r_shadow[i] <= (IW'(i) == r_idx) ? w_upd : r_work[i];
        end
      end
    end
  end

  assign w_px = {{(PW - XW){1'b0}}, bus.position_x};
  assign w_py = {{(PW - YW){1'b0}}, bus.position_y};

  // Priority compositor: scanning high to low leaves the lowest covering index.
  always_comb begin
    w_any = 1'b0;
    w_col = '0;
    for (int i = int'(NUM_BOXES) - 1; i >= 0; i--) begin
      if ((r_shadow[i].x <= w_px) && (w_px < r_shadow[i].x + PW'(BOX_WIDTH)) &&
          (r_shadow[i].y <= w_py) && (w_py < r_shadow[i].y + PW'(BOX_HEIGHT))) begin
        w_any = 1'b1;
        w_col = r_shadow[i].colour;
      end
    end
  end

  // Registered colour output, black outside the active area or any box.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end else if (bus.visible && w_any) begin
      r_r <= {4{w_col[0]}};
      r_g <= {4{w_col[1]}};
      r_b <= {4{w_col[2]}};
    end else begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end
  end

  assign bus.r       = r_r;
  assign bus.g       = r_g;
  assign bus.b       = r_b;
  assign bus.busy    = r_busy;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_bounce_sprites.sv
// Randomised bench for bounce_sprites: a frame-level box model predicts the
// colour of every probed pixel; a monitor pops predictions as outputs appear.
module tb_bounce_sprites;
  import bounce_sprites_pkg::*;

  localparam int NB   = 4;
  localparam int LIMX = 640 - 100;
  localparam int LIMY = 480 - 100;

  logic clk = 1'b0;
  logic rst;

  bounce_sprites_if bus();

  bounce_sprites #(.NUM_BOXES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int mx [NB];
  int my [NB];
  int mxv[NB];
  int myv[NB];
  int mcol[NB];

  logic [11:0] exp_q[$];
  logic drv_v = 1'b0;
  logic pend  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i]   = 50 + 40 * i;
      my[i]   = 50 + 30 * i;
      mxv[i]  = (i % 2 == 1) ? -2 : 2;
      myv[i]  = 1 + (i % 2);
      mcol[i] = (i % 7) + 1;
    end
  endfunction

  function automatic void axis_step(inout int p, inout int v, input int lim, output bit hit);
    int t;
    t   = p + v;
    hit = 1'b0;
    if (t <= 0) begin
      p = 0; v = -v; hit = 1'b1;
    end else if (t >= lim) begin
      p = lim; v = -v; hit = 1'b1;
    end else begin
      p = t;
    end
  endfunction

  function automatic void model_step();
    bit hx, hy;
    for (int i = 0; i < NB; i++) begin
      axis_step(mx[i], mxv[i], LIMX, hx);
      axis_step(my[i], myv[i], LIMY, hy);
      if (hx || hy) mcol[i] = (mcol[i] % 7) + 1;
    end
  endfunction

  function automatic logic [11:0] model_rgb(input int px, input int py, input bit vis);
    int c;
    c = 0;
    if (vis) begin
      for (int i = NB - 1; i >= 0; i--) begin
        if (mx[i] <= px && px < mx[i] + 100 && my[i] <= py && py < my[i] + 100) c = mcol[i];
      end
    end
    return {((c & 1) != 0) ? 4'hF : 4'h0, ((c & 2) != 0) ? 4'hF : 4'h0, ((c & 4) != 0) ? 4'hF : 4'h0};
  endfunction

  task automatic probe(input int px, input int py, input bit vis, input logic [11:0] e);
    @(posedge clk);
    #1;
    bus.position_x = XW'(px);
    bus.position_y = YW'(py);
    bus.visible    = vis;
    drv_v          = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic probe_m(input int px, input int py, input bit vis);
    if (px >= 0 && px < 640 && py >= 0 && py < 480) probe(px, py, vis, model_rgb(px, py, vis));
  endtask

  task automatic probe_end();
    @(posedge clk);
    #1;
    drv_v = 1'b0;
  endtask

  task automatic probe_boxes();
    for (int i = 0; i < NB; i++) begin
      probe_m(mx[i], my[i], 1'b1);
      probe_m(mx[i] + 99, my[i] + 99, 1'b1);
      probe_m(mx[i] - 1, my[i], 1'b1);
      probe_m(mx[i] + 100, my[i] + 50, 1'b1);
    end
    probe_m(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
    probe_m(mx[0] + 10, my[0] + 10, 1'b0);
    probe_end();
  endtask

  task automatic frame(output int cnt);
    @(posedge clk);
    #1 bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // Registered copy of the drive strobe marks cycles whose output is checked.
  always @(posedge clk) pend <= drv_v;

  // Monitor: compare the registered colour against the oldest prediction.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rgb_underflow: got output 0x%0h required a pending prediction", {bus.r, bus.g, bus.b});
        end else begin
          e = exp_q.pop_front();
          chk("rgb", int'({bus.r, bus.g, bus.b}), int'(e));
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit paused;
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.pause      = 1'b0;
    bus.visible    = 1'b0;
    bus.position_x = '0;
    bus.position_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rgb", int'({bus.r, bus.g, bus.b}), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_overrun", int'(bus.overrun), 0);

    // Reset placement: box0 at (50,50) colour 1, box1 at (90,80) colour 2.
    probe(50, 50, 1'b1, 12'hF00);
    probe(150, 150, 1'b1, 12'h0F0);
    probe(49, 50, 1'b1, 12'h000);
    probe_end();

    // First frame: box0 -> (52,51), box1 -> (88,82); box0 wins on overlap.
    frame(cnt);
    chk("busy_cycles_first", cnt, 4);
    model_step();
    probe(52, 51, 1'b1, 12'hF00);
    probe(51, 51, 1'b1, 12'h000);
    probe(100, 100, 1'b1, 12'hF00);
    probe(160, 100, 1'b1, 12'h0F0);
    probe(88, 181, 1'b1, 12'h0F0);
    probe(88, 182, 1'b1, 12'h000);
    probe(100, 100, 1'b0, 12'h000);
    probe_end();

    // Long random run with occasional paused ticks; walls and colour wraps occur.
    for (int f = 0; f < 1000; f++) begin
      paused    = ($urandom_range(0, 9) == 0);
      bus.pause = paused;
      frame(cnt);
      bus.pause = 1'b0;
      chk(paused ? "busy_cycles_paused" : "busy_cycles", cnt, paused ? 0 : 4);
      if (!paused) model_step();
      probe_boxes();
    end
    chk("overrun_clear", int'(bus.overrun), 0);

    // Tick on the second update cycle: ignored, flagged, single step only.
    @(posedge clk);
    #1 bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
    @(posedge clk);
    #1 bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("overrun_set", int'(bus.overrun), 1);
    chk("overrun_sweep_done", int'(bus.busy), 0);
    model_step();
    repeat (3) @(posedge clk);
    #1 chk("overrun_no_retrigger", int'(bus.busy), 0);
    probe_boxes();

    // Paused tick must leave everything frozen.
    bus.pause = 1'b1;
    frame(cnt);
    chk("pause_busy", cnt, 0);
    bus.pause = 1'b0;
    probe_boxes();

    // Reset on the second update cycle aborts the sweep.
    @(posedge clk);
    #1 bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
    chk("pre_abort_busy", int'(bus.busy), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_overrun", int'(bus.overrun), 0);
    chk("abort_rgb", int'({bus.r, bus.g, bus.b}), 0);
    rst = 1'b0;
    model_reset();
    probe(50, 50, 1'b1, 12'hF00);
    probe(150, 150, 1'b1, 12'h0F0);
    probe_end();
    probe_boxes();

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
